// File: rtl/friscv_clint_ctrl.sv
// -----------------------------------------------------------------------------
// friscv_clint_ctrl
//
// Core-local interrupt controller for a single hart. Owns msip, the 64-bit
// mtime counter and the 64-bit mtimecmp comparator. The core reads and writes
// them through single-beat valid/ready accesses. The controller drives
// sw_irq and timer_irq to the hart.
//
// Ports:
//   aclk, srst          system clock, synchronous active-high reset
//   rtc                 asynchronous real-time tick source (rising edge = +1)
//   req_valid/ready     request handshake
//   req_wr              1 = write, 0 = read
//   req_addr            byte offset into the CLINT region (bits 1:0 ignored)
//   req_wdata/wstrb     write data and byte enables
//   rsp_valid/ready     response handshake
//   rsp_rdata/err       read data (0 for writes), unmapped-offset flag
//   sw_irq, timer_irq   registered interrupt outputs
// -----------------------------------------------------------------------------
module friscv_clint_ctrl #(
    parameter int XLEN  = 32,
    parameter int ADDRW = 16
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic              rtc,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDRW-1:0]  req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN/8-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              sw_irq,
    output logic              timer_irq
);

    localparam logic [ADDRW-1:0] OFF_MSIP       = ADDRW'(16'h0000);
    localparam logic [ADDRW-1:0] OFF_MTIMECMP_L = ADDRW'(16'h4000);
    localparam logic [ADDRW-1:0] OFF_MTIMECMP_H = ADDRW'(16'h4004);
    localparam logic [ADDRW-1:0] OFF_MTIME_L    = ADDRW'(16'hBFF8);
    localparam logic [ADDRW-1:0] OFF_MTIME_H    = ADDRW'(16'hBFFC);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t            state_reg;
    logic              req_ready_reg;
    logic              rsp_valid_reg;
    logic [XLEN-1:0]   rsp_rdata_reg;
    logic              rsp_err_reg;
    logic              sw_irq_reg;
    logic              timer_irq_reg;

    logic              msip_reg;
    logic [63:0]       mtime_reg;
    logic [63:0]       mtime_next;
    logic [63:0]       mtimecmp_reg;

    // rtc crosses into aclk through two flops; the third flop remembers the
    // previous synchronized level so a rising edge yields a one-cycle tick.
    logic              rtc_meta_reg;
    logic              rtc_sync_reg;
    logic              rtc_prev_reg;
    logic              tick;

    logic              accept;
    logic [ADDRW-1:0]  addr_aligned;
    logic              sel_msip, sel_cmp_l, sel_cmp_h, sel_time_l, sel_time_h;
    logic              hit;
    logic              wr_msip, wr_cmp_l, wr_cmp_h, wr_time_l, wr_time_h;
    logic [XLEN-1:0]   wmask;
    logic [XLEN-1:0]   rdata_mux;

    assign tick   = rtc_sync_reg & ~rtc_prev_reg;
    assign accept = req_valid & req_ready_reg;

    // Clear the byte-lane bits so decode works on the word address only.
    assign addr_aligned = req_addr & ~ADDRW'(3);

    assign sel_msip   = (addr_aligned == OFF_MSIP);
    assign sel_cmp_l  = (addr_aligned == OFF_MTIMECMP_L);
    assign sel_cmp_h  = (addr_aligned == OFF_MTIMECMP_H);
    assign sel_time_l = (addr_aligned == OFF_MTIME_L);
    assign sel_time_h = (addr_aligned == OFF_MTIME_H);
    assign hit        = sel_msip | sel_cmp_l | sel_cmp_h | sel_time_l | sel_time_h;

    assign wr_msip   = accept & req_wr & sel_msip;
    assign wr_cmp_l  = accept & req_wr & sel_cmp_l;
    assign wr_cmp_h  = accept & req_wr & sel_cmp_h;
    assign wr_time_l = accept & req_wr & sel_time_l;
    assign wr_time_h = accept & req_wr & sel_time_h;

    // Expand byte strobes into a bit mask.
    generate
        for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{req_wstrb[gi]}};
        end
    endgenerate

    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_val,
                                              input logic [XLEN-1:0] new_val,
                                              input logic [XLEN-1:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    always_comb begin
        rdata_mux = '0;
        if (sel_msip)   rdata_mux = {{(XLEN-1){1'b0}}, msip_reg};
        if (sel_cmp_l)  rdata_mux = mtimecmp_reg[31:0];
        if (sel_cmp_h)  rdata_mux = mtimecmp_reg[63:32];
        if (sel_time_l) rdata_mux = mtime_reg[31:0];
        if (sel_time_h) rdata_mux = mtime_reg[63:32];
    end

    // A write to either mtime word suppresses that cycle's tick for the whole
    // 64-bit value, so software never sees a half-incremented result.
    always_comb begin
        mtime_next = mtime_reg;
        if (wr_time_l || wr_time_h) begin
            if (wr_time_l) mtime_next[31:0]  = merge(mtime_reg[31:0],  req_wdata, wmask);
            if (wr_time_h) mtime_next[63:32] = merge(mtime_reg[63:32], req_wdata, wmask);
        end else if (tick) begin
            mtime_next = mtime_reg + 64'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            sw_irq_reg    <= 1'b0;
            timer_irq_reg <= 1'b0;
            msip_reg      <= 1'b0;
            mtime_reg     <= '0;
            mtimecmp_reg  <= '1;
            rtc_meta_reg  <= 1'b0;
            rtc_sync_reg  <= 1'b0;
            rtc_prev_reg  <= 1'b0;
        end else begin
            rtc_meta_reg  <= rtc;
            rtc_sync_reg  <= rtc_meta_reg;
            rtc_prev_reg  <= rtc_sync_reg;

            mtime_reg     <= mtime_next;
            if (wr_cmp_l) mtimecmp_reg[31:0]  <= merge(mtimecmp_reg[31:0],  req_wdata, wmask);
            if (wr_cmp_h) mtimecmp_reg[63:32] <= merge(mtimecmp_reg[63:32], req_wdata, wmask);
            if (wr_msip && req_wstrb[0]) msip_reg <= req_wdata[0];

            sw_irq_reg    <= msip_reg;
            timer_irq_reg <= (mtime_reg >= mtimecmp_reg);

            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        state_reg     <= ST_RESP;
                        req_ready_reg <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= req_wr ? '0 : rdata_mux;
                        rsp_err_reg   <= ~hit;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= ST_IDLE;
                        req_ready_reg <= 1'b1;
                        rsp_valid_reg <= 1'b0;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign sw_irq    = sw_irq_reg;
    assign timer_irq = timer_irq_reg;

endmodule

// File: tb/tb_friscv_clint_ctrl.sv
// -----------------------------------------------------------------------------
// tb_friscv_clint_ctrl
//
// Directed bench for friscv_clint_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge. Each comparison is an immediate
// assertion against a hand-computed value.
// -----------------------------------------------------------------------------
module tb_friscv_clint_ctrl;

    logic        aclk;
    logic        srst;
    logic        rtc;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sw_irq;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    friscv_clint_ctrl #(.XLEN(32), .ADDRW(16)) dut (
        .aclk      (aclk),
        .srst      (srst),
        .rtc       (rtc),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sw_irq    (sw_irq),
        .timer_irq (timer_irq)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full access with rsp_ready held high. Returns at the falling edge
    // after the response has been consumed.
    task automatic access(input logic wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output logic err);
        int n;
        @(negedge aclk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        rsp_ready = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        @(negedge aclk);
        req_valid = 1'b0;
        chk("rsp_latency", 32'(rsp_valid), 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge aclk);
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        $display("access wr=%0d addr=%h wdata=%h wstrb=%h -> rdata=%h err=%0d",
                 wr, addr, wdata, wstrb, rdata, err);
    endtask

    task automatic rtc_pulse();
        @(negedge aclk);
        rtc = 1'b1;
        repeat (3) @(negedge aclk);
        rtc = 1'b0;
        repeat (3) @(negedge aclk);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        srst      = 1'b1;
        rtc       = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b0;

        // Reset and idle
        repeat (3) @(negedge aclk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        srst = 1'b0;
        @(negedge aclk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_timer_irq", 32'(timer_irq), 32'd0);
        chk("idle_sw_irq", 32'(sw_irq), 32'd0);
        access(1'b0, 16'hBFF8, 32'h0, 4'h0, rd, er);
        chk("rst_mtime_lo", rd, 32'h0);
        access(1'b0, 16'h4004, 32'h0, 4'h0, rd, er);
        chk("rst_mtimecmp_hi", rd, 32'hFFFF_FFFF);
        chk("rst_mtimecmp_hi_err", 32'(er), 32'd0);

        // msip / sw_irq
        access(1'b1, 16'h0000, 32'h1, 4'hF, rd, er);
        chk("msip_wr_err", 32'(er), 32'd0);
        chk("msip_wr_rdata", rd, 32'h0);
        chk("sw_irq_set", 32'(sw_irq), 32'd1);
        access(1'b0, 16'h0000, 32'h0, 4'h0, rd, er);
        chk("msip_read", rd, 32'h1);
        access(1'b1, 16'h0000, 32'hFFFF_FFFE, 4'hF, rd, er);
        chk("sw_irq_clear", 32'(sw_irq), 32'd0);
        access(1'b0, 16'h0000, 32'h0, 4'h0, rd, er);
        chk("msip_read_zero", rd, 32'h0);

        // timer compare
        access(1'b1, 16'h4000, 32'h5, 4'hF, rd, er);
        access(1'b1, 16'h4004, 32'h0, 4'hF, rd, er);
        chk("timer_before", 32'(timer_irq), 32'd0);
        repeat (4) rtc_pulse();
        chk("timer_at_4", 32'(timer_irq), 32'd0);
        // Fifth pulse, timed edge by edge: mtime becomes 5 at the third rising
        // edge after rtc rises, timer_irq one edge later.
        @(negedge aclk);
        rtc = 1'b1;
        repeat (3) @(negedge aclk);
        chk("timer_lag", 32'(timer_irq), 32'd0);
        @(negedge aclk);
        chk("timer_fire", 32'(timer_irq), 32'd1);
        rtc = 1'b0;
        repeat (3) @(negedge aclk);
        access(1'b0, 16'hBFF8, 32'h0, 4'h0, rd, er);
        chk("mtime_5", rd, 32'h5);
        access(1'b1, 16'h4004, 32'h1, 4'hF, rd, er);
        chk("timer_clear", 32'(timer_irq), 32'd0);

        // 64-bit wrap
        access(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, er);
        access(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, er);
        chk("timer_max", 32'(timer_irq), 32'd1);
        rtc_pulse();
        access(1'b0, 16'hBFF8, 32'h0, 4'h0, rd, er);
        chk("wrap_lo", rd, 32'h0);
        access(1'b0, 16'hBFFC, 32'h0, 4'h0, rd, er);
        chk("wrap_hi", rd, 32'h0);
        chk("timer_after_wrap", 32'(timer_irq), 32'd0);

        // Tick colliding with a write to mtime lo: the write wins
        @(negedge aclk);
        rtc = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'hBFF8;
        req_wdata = 32'h10;
        req_wstrb = 4'hF;
        rsp_ready = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        chk("coll_rsp_valid", 32'(rsp_valid), 32'd1);
        @(negedge aclk);
        rtc = 1'b0;
        repeat (3) @(negedge aclk);
        access(1'b0, 16'hBFF8, 32'h0, 4'h0, rd, er);
        chk("coll_mtime_lo", rd, 32'h10);
        access(1'b0, 16'hBFFC, 32'h0, 4'h0, rd, er);
        chk("coll_mtime_hi", rd, 32'h0);

        // Byte strobes: lanes 0 and 2 only
        access(1'b1, 16'h4000, 32'hAABB_CCDD, 4'b0101, rd, er);
        access(1'b0, 16'h4000, 32'h0, 4'h0, rd, er);
        chk("wstrb_merge", rd, 32'h00BB_00DD);

        // Response backpressure
        @(negedge aclk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 16'h4004;
        rsp_ready = 1'b0;
        @(negedge aclk);
        req_valid = 1'b0;
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rdata", rsp_rdata, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_rdata", rsp_rdata, 32'h1);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);

        // Unmapped offsets
        access(1'b0, 16'h1234, 32'h0, 4'h0, rd, er);
        chk("unmapped_rd_data", rd, 32'h0);
        chk("unmapped_rd_err", 32'(er), 32'd1);
        access(1'b1, 16'h0004, 32'hFFFF_FFFF, 4'hF, rd, er);
        chk("unmapped_wr_err", 32'(er), 32'd1);
        access(1'b0, 16'h4000, 32'h0, 4'h0, rd, er);
        chk("mapped_rd_err", 32'(er), 32'd0);

        // Reset while a response is pending
        @(negedge aclk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 16'h4004;
        rsp_ready = 1'b0;
        @(negedge aclk);
        req_valid = 1'b0;
        chk("midrst_pending", 32'(rsp_valid), 32'd1);
        srst = 1'b1;
        @(negedge aclk);
        chk("midrst_dropped", 32'(rsp_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        srst = 1'b0;
        @(negedge aclk);
        access(1'b0, 16'h4004, 32'h0, 4'h0, rd, er);
        chk("midrst_mtimecmp_hi", rd, 32'hFFFF_FFFF);
        access(1'b0, 16'h4000, 32'h0, 4'h0, rd, er);
        chk("midrst_mtimecmp_lo", rd, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
